// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and default parameters for button_conditioner
package button_pkg;

  // Bit 1 set means the debounced level is high.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_DELAY_DEF    = 8;
  localparam int REPEAT_PERIOD_DEF   = 3;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced button with press strobe; auto-repeat under BUTTON_CONDITIONER_AUTOREPEAT_EN
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse,
  output logic level
);

  // The sample that moves the FSM into a wait state counts as the first stable
  // sample, so the wait state exits once the counter reaches DEBOUNCE_CYCLES-1
  // (but always stays at least one cycle).
  localparam logic [7:0] DB_LAST = (DEBOUNCE_CYCLES > 1) ? 8'(DEBOUNCE_CYCLES - 1) : 8'd1;

  logic       sync;
  btn_state_t state, next_state;
  logic [7:0] cnt, cnt_d;
  logic       press_pulse;
  logic       rep_pulse;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      pulse <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
      pulse <= press_pulse | rep_pulse;
    end
  end

  always_comb begin
    next_state  = state;
    cnt_d       = 8'd0;
    press_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          next_state = PRESS_WAIT;
          cnt_d      = 8'd1;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          next_state = IDLE;
        end else if (cnt >= DB_LAST) begin
          next_state  = PRESSED;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      PRESSED: begin
        if (!sync) begin
          next_state = RELEASE_WAIT;
          cnt_d      = 8'd1;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          next_state = PRESSED;
        end else if (cnt >= DB_LAST) begin
          next_state = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign level = state[1];

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

  logic [15:0] hold, hold_d;
  logic        rep, rep_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= 16'd0;
      rep  <= 1'b0;
    end else begin
      hold <= hold_d;
      rep  <= rep_d;
    end
  end

  // rep selects the first-delay threshold versus the steady repeat period.
  always_comb begin
    hold_d    = 16'd0;
    rep_d     = 1'b0;
    rep_pulse = 1'b0;
    if (state == PRESSED && next_state == PRESSED) begin
      if (hold == (rep ? PERIOD_LAST : DELAY_LAST)) begin
        rep_pulse = 1'b1;
        rep_d     = 1'b1;
      end else begin
        hold_d = hold + 16'd1;
        rep_d  = rep;
      end
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic pulse;
  logic level;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int plog[$];
  int exp_q[$];

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .pulse   (pulse),
    .level   (level)
  );

  // Outputs are observed 1 time unit after each rising edge; pulses are logged by edge number.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (pulse !== 1'b0) plog.push_back(edge_n);
  endtask

  task automatic tick_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int k, p, j, r, dropped;
    logic exp_rep;

    // Reset overrides a high button.
    reset   = 1'b1;
    btn_raw = 1'b1;
    repeat (3) tick();
    chk("reset_pulse", 32'(pulse), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    btn_raw = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_level", 32'(level), 32'd0);

    // Clean press: first sample at edge k, pulse only after edge k+5.
    plog.delete();
    btn_raw = 1'b1;
    k = edge_n + 1;
    tick_to(k + 4);
    chk("clean_pre_pulse", 32'(pulse), 32'd0);
    chk("clean_pre_level", 32'(level), 32'd0);
    tick();
    chk("clean_pulse", 32'(pulse), 32'd1);
    chk("clean_level", 32'(level), 32'd1);
    tick();
    chk("clean_pulse_single", 32'(pulse), 32'd0);
    chk("clean_level_held", 32'(level), 32'd1);

    // Hold for 29 cycles after p0 and compare the pulse schedule.
    p = k + 5;
    tick_to(p + 29);
    exp_q.delete();
    exp_q.push_back(p);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    for (int t = 8; t <= 29; t += 3) exp_q.push_back(p + t);
`endif
    chk("hold_pulse_count", 32'(plog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < plog.size(); i++)
      chk($sformatf("hold_pulse_edge%0d", i), 32'(plog[i]), 32'(exp_q[i]));

    // Release: level falls 5 edges after the first low sample, no pulse.
    plog.delete();
    btn_raw = 1'b0;
    j = edge_n + 1;
    tick_to(j + 4);
    chk("release_level_hold", 32'(level), 32'd1);
    tick();
    chk("release_level_fall", 32'(level), 32'd0);
    repeat (5) tick();
    chk("release_no_pulse", 32'(plog.size()), 32'd0);

    // Bounce: 3 high, 1 low, then high and held.
    plog.delete();
    btn_raw = 1'b1;
    repeat (3) tick();
    btn_raw = 1'b0;
    tick();
    btn_raw = 1'b1;
    k = edge_n + 1;
    tick_to(k + 4);
    chk("bounce_no_early_pulse", 32'(plog.size()), 32'd0);
    tick();
    chk("bounce_pulse", 32'(pulse), 32'd1);
    chk("bounce_level", 32'(level), 32'd1);

    // Release glitch of 2 samples while pressed.
    p = edge_n;
    plog.delete();
    btn_raw = 1'b0;
    repeat (2) tick();
    btn_raw = 1'b1;
    dropped = 0;
    while (edge_n < p + 12) begin
      tick();
      if (level !== 1'b1) dropped++;
    end
    chk("glitch_level_drops", 32'(dropped), 32'd0);
    chk("glitch_no_pulse", 32'(plog.size()), 32'd0);
    tick();
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    exp_rep = 1'b1;
`else
    exp_rep = 1'b0;
`endif
    chk("glitch_schedule_restart", 32'(pulse), 32'(exp_rep));

    // Reset mid-press at p0+2 with the button still held.
    btn_raw = 1'b0;
    repeat (12) tick();
    chk("pre_reset_idle_level", 32'(level), 32'd0);
    btn_raw = 1'b1;
    k = edge_n + 1;
    tick_to(k + 5);
    chk("press2_pulse", 32'(pulse), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    r = edge_n;
    chk("midreset_pulse", 32'(pulse), 32'd0);
    chk("midreset_level", 32'(level), 32'd0);
    reset = 1'b0;
    plog.delete();
    tick_to(r + 5);
    chk("postreset_no_early_pulse", 32'(plog.size()), 32'd0);
    chk("postreset_early_level", 32'(level), 32'd0);
    tick();
    chk("postreset_pulse", 32'(pulse), 32'd1);
    chk("postreset_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
